conv_encoder_frame: RTL

- Rate-1/2 feed-forward convolutional encoder. It is the transmit-side counterpart of the Viterbi traceback/output stage.
- Accepts a DATA_W-bit frame word through a valid/ready handshake and serialises it LSB first.
- Emits one 2-bit coded symbol per accepted bit, then K-1 zero tail symbols so the trellis terminates in state 0, which is where traceback starts.
- Sits between the data source and the channel/branch-metric stage. Output symbols support downstream backpressure.

---
 rtl/conv_encoder_frame.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame: rate-1/2 feed-forward convolutional encoder with a frame interface.
// Accepts a DATA_W-bit word over valid/ready and serialises it LSB first. For every
// accepted bit it emits one 2-bit symbol: bit1 = parity(G0 & v), bit0 = parity(G1 & v),
// where v = {u, state}.
//
// Build option ZERO_TAIL_EN:
//   - Defined: K-1 zero tail symbols follow the data, which returns the state to 0.
//   - Undefined: frames are DATA_W symbols long, and the state carries across frames.
//
// Ports:
//   clk, rst     - rising-edge clock; synchronous active-high reset
//   i_data       - frame word; bit 0 is encoded first
//   i_valid      - i_data is valid
//   o_ready      - encoder can accept a frame (registered)
//   o_sym        - coded symbol (registered)
//   o_sym_valid  - o_sym is valid (registered)
//   i_sym_ready  - downstream accepts o_sym this cycle
//   o_done       - current symbol is the last symbol of the frame (registered)
//   o_state      - encoder shift-register state
module conv_encoder_frame #(
    parameter int unsigned  DATA_W = 20,
    parameter int unsigned  K      = 3,
    parameter logic [K-1:0] G0     = 3'b111,
    parameter logic [K-1:0] G1     = 3'b101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [1:0]        o_sym,
    output logic              o_sym_valid,
    input  logic              i_sym_ready,
    output logic              o_done,
    output logic [K-2:0]      o_state
);

    localparam int unsigned SW = K - 1;
`ifdef ZERO_TAIL_EN
    localparam int unsigned TAIL_LEN = K - 1;
`else
    localparam int unsigned TAIL_LEN = 0;
`endif
    localparam int unsigned FRAME_LEN = DATA_W + TAIL_LEN;
    localparam int unsigned CW        = $clog2(DATA_W + K);

`ifdef ZERO_TAIL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, TAIL = 2'd2} fsm_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1} fsm_t;
`endif

    // Symbol for input bit u entering state s.
    function automatic logic [1:0] encode(input logic u, input logic [SW-1:0] s);
        logic [K-1:0] v;
        v = {u, s};
        return {^(G0 & v), ^(G1 & v)};
    endfunction

    fsm_t              fsm;
    logic [DATA_W-1:0] data_sr;
    logic [CW-1:0]     cnt;

    logic              u_cur;
    logic              u_nxt;
    logic [SW-1:0]     s_adv;
    logic [DATA_W-1:0] sr_adv;
    logic [CW-1:0]     cnt_adv;
    logic              tail_next;
    logic              last_xfer;
    logic              done_next;

    // Values after the currently presented symbol is accepted. The symbol for the
    // next bit is precomputed here so that o_sym can be a plain register.
    always_comb begin
        u_cur     = (fsm == ENC) ? data_sr[0] : 1'b0;
        s_adv     = SW'({u_cur, o_state} >> 1);
        sr_adv    = data_sr >> 1;
        cnt_adv   = cnt + CW'(1);
        tail_next = (cnt_adv >= CW'(DATA_W));
        u_nxt     = tail_next ? 1'b0 : sr_adv[0];
        last_xfer = (cnt_adv == CW'(FRAME_LEN));
        done_next = (cnt_adv == CW'(FRAME_LEN - 1));
    end

    // Frame FSM. Symbol outputs only move on an accepted transfer, so they are stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            data_sr     <= '0;
            cnt         <= '0;
            o_state     <= '0;
            o_sym       <= '0;
            o_sym_valid <= 1'b0;
            o_done      <= 1'b0;
            o_ready     <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    o_ready     <= 1'b1;
                    o_sym_valid <= 1'b0;
                    o_done      <= 1'b0;
                    if (i_valid && o_ready) begin
                        data_sr     <= i_data;
                        cnt         <= '0;
                        fsm         <= ENC;
                        o_ready     <= 1'b0;
                        o_sym_valid <= 1'b1;
                        o_sym       <= encode(i_data[0], o_state);
                        o_done      <= (FRAME_LEN == 1);
                    end
                end
`ifdef ZERO_TAIL_EN
                ENC, TAIL: begin
`else
                ENC: begin
`endif
                    if (i_sym_ready) begin
                        o_state <= s_adv;
                        data_sr <= sr_adv;
                        cnt     <= cnt_adv;
                        if (last_xfer) begin
                            fsm         <= IDLE;
                            o_ready     <= 1'b1;
                            o_sym_valid <= 1'b0;
                            o_sym       <= '0;
                            o_done      <= 1'b0;
                        end else begin
                            o_sym  <= encode(u_nxt, s_adv);
                            o_done <= done_next;
`ifdef ZERO_TAIL_EN
                            if (tail_next) begin
                                fsm <= TAIL;
                            end
`endif
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
